// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the deadlock persistence filter.
//   dl_state_e : filter FSM states (RUN / SUSPECT / DEADLOCK)
//   sat_inc    : saturating increment of a counter of a given bit width
//                (width up to 32)
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } dl_state_e;

  // Returns value+1, holding at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    sat_inc = (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/deadlock_lsb_index.sv
// Lowest-set-bit encoder.
//   vec : input bit vector (NUM_AXIS bits)
//   idx : index of the lowest set bit of vec; 0 when vec is all zero
module deadlock_lsb_index #(
  parameter int NUM_AXIS = 2,
  parameter int IDX_W    = 1
) (
  input  logic [NUM_AXIS-1:0] vec,
  output logic [IDX_W-1:0]    idx
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_AXIS; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deadlock_persist_filter.sv
// Debounced, latched deadlock verdict from per-cycle block/idle samples.
// A deadlock is declared once the stall condition has held for THRESH
// consecutive cycles; the blocked stream channels are captured at entry and
// entry/stall statistics are accumulated.
//   kernel_monitor_clock : clock, rising edge
//   kernel_monitor_reset : synchronous, active-low reset
//   axis_block_sigs      : per stream channel blocked flags
//   inst_idle_sigs       : per instance idle flags
//   inst_block_sigs      : per instance blocked flags
//   clear                : synchronous clear of block_events / stall_cycles
//   block                : deadlock verdict (level)
//   block_rise           : one-cycle pulse on deadlock entry
//   blocked_snapshot     : axis_block_sigs captured at entry
//   first_idx            : lowest set index of blocked_snapshot
//   block_events         : saturating count of deadlock entries
//   stall_cycles         : saturating count of cycles spent in DEADLOCK
module deadlock_persist_filter
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_rise,
  output logic [NUM_AXIS-1:0] blocked_snapshot,
  output logic [IDX_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    block_events,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int              PCNT_W    = $clog2(THRESH);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(THRESH - 1);

  dl_state_e             state_q, state_d;
  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic                  block_q, block_d;
  logic                  block_rise_q, block_rise_d;
  logic [NUM_AXIS-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]      first_idx_q, first_idx_d;
  logic [CNT_W-1:0]      events_q, events_d;
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic                  stuck;
  logic                  entering;
  logic [IDX_W-1:0]      lsb_idx;
  logic [31:0]           events_inc;
  logic [31:0]           stall_inc;

  assign stuck = (|axis_block_sigs) & (&(inst_idle_sigs | inst_block_sigs));

  deadlock_lsb_index #(
    .NUM_AXIS (NUM_AXIS),
    .IDX_W    (IDX_W)
  ) u_lsb_index (
    .vec (axis_block_sigs),
    .idx (lsb_idx)
  );

  // Next-state and persistence counter.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      RUN: begin
        if (stuck) begin
          state_d = SUSPECT;
          pcnt_d  = PCNT_W'(1);
        end else begin
          pcnt_d  = '0;
        end
      end
      SUSPECT: begin
        if (!stuck) begin
          state_d = RUN;
          pcnt_d  = '0;
        end else if (pcnt_q == PCNT_LAST) begin
          state_d = DEADLOCK;
        end else begin
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end
      end
      DEADLOCK: begin
        if (!stuck) begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        pcnt_d  = '0;
      end
    endcase
  end

  // Registered outputs, capture and statistics; clear overrides increments.
  always_comb begin
    entering     = (state_q == SUSPECT) && (state_d == DEADLOCK);
    block_d      = (state_d == DEADLOCK);
    block_rise_d = entering;
    snap_d       = entering ? axis_block_sigs : snap_q;
    first_idx_d  = entering ? lsb_idx : first_idx_q;

    events_inc = sat_inc(32'(events_q), CNT_W);
    stall_inc  = sat_inc(32'(stall_q), CNT_W);

    events_d = entering ? events_inc[CNT_W-1:0] : events_q;
    stall_d  = (state_q == DEADLOCK) ? stall_inc[CNT_W-1:0] : stall_q;
    if (clear) begin
      events_d = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (!kernel_monitor_reset) begin
      state_q      <= RUN;
      pcnt_q       <= '0;
      block_q      <= 1'b0;
      block_rise_q <= 1'b0;
      snap_q       <= '0;
      first_idx_q  <= '0;
      events_q     <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      block_q      <= block_d;
      block_rise_q <= block_rise_d;
      snap_q       <= snap_d;
      first_idx_q  <= first_idx_d;
      events_q     <= events_d;
      stall_q      <= stall_d;
    end
  end

  assign block            = block_q;
  assign block_rise       = block_rise_q;
  assign blocked_snapshot = snap_q;
  assign first_idx        = first_idx_q;
  assign block_events     = events_q;
  assign stall_cycles     = stall_q;

endmodule
